// File: rtl/gci_std_display_pixel_unpacker.sv
// Display-domain VRAM read back end: pops packed words from a show-ahead FIFO
// and hands them out one pixel per display request.
module gci_std_display_pixel_unpacker #(
    parameter int                 P_WORD_W          = 32,
    parameter int                 P_PIX_W           = 16,
    parameter int                 P_LINE_PIXELS     = 640,
    parameter logic [P_PIX_W-1:0] P_UNDERFLOW_COLOR = '0
) (
    input  logic                iDISP_CLOCK,
    input  logic                inRESET,
    input  logic                iRESET_SYNC,
    input  logic                iMODE_ORDER,
    input  logic                iMODE_HDOUBLE,
    input  logic                iFIFO_EMPTY,
    input  logic [P_WORD_W-1:0] iFIFO_DATA,
    output logic                oFIFO_RD_EN,
    input  logic                iDISP_REQ,
    output logic                oDISP_VALID,
    output logic [P_PIX_W-1:0]  oDISP_DATA,
    output logic                oUNDERFLOW,
    output logic                oLINE_END
);
    localparam int N     = P_WORD_W / P_PIX_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int LC_W  = (P_LINE_PIXELS > 1) ? $clog2(P_LINE_PIXELS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(P_LINE_PIXELS - 1);

    logic [P_WORD_W-1:0] hold_word_q, hold_word_d;
    logic                hold_valid_q, hold_valid_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                rep_q, rep_d;
    logic                order_q, order_d;
    logic                hdbl_q, hdbl_d;
    logic [LC_W-1:0]     line_q, line_d;
    logic                unf_q, unf_d;
    logic                lend_q, lend_d;

    logic [N-1:0][P_PIX_W-1:0] pix_w;
    logic [IDX_W-1:0]          slot_w;
    logic                      consume_w, advance_w, exhaust_w, rd_en_w;

    assign pix_w  = hold_word_q;
    assign slot_w = order_q ? (IDX_LAST - idx_q) : idx_q;

    assign consume_w = !iRESET_SYNC && iDISP_REQ && hold_valid_q;
    // In doubling mode the first request of each pixel only flips the phase.
    assign advance_w = consume_w && !(hdbl_q && !rep_q);
    assign exhaust_w = advance_w && (idx_q == IDX_LAST);
    assign rd_en_w   = !iRESET_SYNC && !iFIFO_EMPTY && (!hold_valid_q || exhaust_w);

    always_comb begin
        hold_word_d  = hold_word_q;
        hold_valid_d = hold_valid_q;
        idx_d        = idx_q;
        rep_d        = rep_q;
        order_d      = order_q;
        hdbl_d       = hdbl_q;
        line_d       = line_q;
        unf_d        = unf_q;
        lend_d       = 1'b0;
        if (iRESET_SYNC) begin
            hold_valid_d = 1'b0;
            idx_d        = '0;
            rep_d        = 1'b0;
            line_d       = '0;
            unf_d        = 1'b0;
            order_d      = iMODE_ORDER;
            hdbl_d       = iMODE_HDOUBLE;
        end else begin
            // Line counter follows display timing, not data availability.
            if (iDISP_REQ) begin
                if (line_q == LC_LAST) begin
                    line_d = '0;
                    lend_d = 1'b1;
                end else begin
                    line_d = line_q + 1'b1;
                end
                if (!hold_valid_q)
                    unf_d = 1'b1;
            end
            if (consume_w) begin
                if (!advance_w) begin
                    rep_d = 1'b1;
                end else begin
                    rep_d = 1'b0;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            if (rd_en_w) begin
                hold_word_d  = iFIFO_DATA;
                hold_valid_d = 1'b1;
                idx_d        = '0;
                rep_d        = 1'b0;
            end else if (exhaust_w) begin
                hold_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge iDISP_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            hold_word_q  <= '0;
            hold_valid_q <= 1'b0;
            idx_q        <= '0;
            rep_q        <= 1'b0;
            order_q      <= 1'b0;
            hdbl_q       <= 1'b0;
            line_q       <= '0;
            unf_q        <= 1'b0;
            lend_q       <= 1'b0;
        end else begin
            hold_word_q  <= hold_word_d;
            hold_valid_q <= hold_valid_d;
            idx_q        <= idx_d;
            rep_q        <= rep_d;
            order_q      <= order_d;
            hdbl_q       <= hdbl_d;
            line_q       <= line_d;
            unf_q        <= unf_d;
            lend_q       <= lend_d;
        end
    end

    assign oFIFO_RD_EN = rd_en_w;
    assign oDISP_VALID = hold_valid_q;
    assign oDISP_DATA  = hold_valid_q ? pix_w[slot_w] : P_UNDERFLOW_COLOR;
    assign oUNDERFLOW  = unf_q;
    assign oLINE_END   = lend_q;
endmodule

// File: tb/tb_gci_std_display_pixel_unpacker.sv
// Bench for the pixel unpacker: a 32/16 instance and a 64/8 instance share one
// stimulus path, selected by sel; a FIFO model feeds words and a scoreboard checks pixels.
module tb_gci_std_display_pixel_unpacker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0, order = 1'b0, hdbl = 1'b0, req = 1'b0, sel = 1'b0;
    logic        f_empty = 1'b1;
    logic [63:0] f_data = '0;

    logic        rd0, vld0, unf0, lend0, rd1, vld1, unf1, lend1;
    logic [15:0] pix0;
    logic [7:0]  pix1;
    logic        rd_o, vld_o, unf_o, lend_o;
    logic [63:0] pix_o;

    always #5 clk = ~clk;

    gci_std_display_pixel_unpacker #(.P_WORD_W(32), .P_PIX_W(16), .P_LINE_PIXELS(640)) dut0 (
        .iDISP_CLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(sync),
        .iMODE_ORDER(order), .iMODE_HDOUBLE(hdbl),
        .iFIFO_EMPTY(f_empty | sel), .iFIFO_DATA(f_data[31:0]), .oFIFO_RD_EN(rd0),
        .iDISP_REQ(req & ~sel), .oDISP_VALID(vld0), .oDISP_DATA(pix0),
        .oUNDERFLOW(unf0), .oLINE_END(lend0));

    gci_std_display_pixel_unpacker #(.P_WORD_W(64), .P_PIX_W(8), .P_LINE_PIXELS(8)) dut1 (
        .iDISP_CLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(sync),
        .iMODE_ORDER(order), .iMODE_HDOUBLE(hdbl),
        .iFIFO_EMPTY(f_empty | ~sel), .iFIFO_DATA(f_data), .oFIFO_RD_EN(rd1),
        .iDISP_REQ(req & sel), .oDISP_VALID(vld1), .oDISP_DATA(pix1),
        .oUNDERFLOW(unf1), .oLINE_END(lend1));

    assign rd_o   = sel ? rd1 : rd0;
    assign vld_o  = sel ? vld1 : vld0;
    assign unf_o  = sel ? unf1 : unf0;
    assign lend_o = sel ? lend1 : lend0;
    assign pix_o  = sel ? {56'd0, pix1} : {48'd0, pix0};

    typedef struct {
        logic        sel, ord, hd;
        int          nw;
        logic [63:0] w0, w1;
        logic [63:0] first;
        int          pops;
    } vec_t;
    vec_t vt[6];

    logic [63:0] fifo_q[$];
    logic [63:0] exp_q[$];
    int total = 0, bad = 0;
    int pops, bubbles, lend_cnt;
    logic last_rd;
    int   lc_m[2];
    logic lend_m[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic void push_word(input logic [63:0] w, input logic s, input logic o, input logic h);
        int n  = s ? 8 : 2;
        int pw = s ? 8 : 16;
        logic [63:0] mask = (64'd1 << pw) - 64'd1;
        fifo_q.push_back(w);
        for (int i = 0; i < n; i++) begin
            int k = o ? (n - 1 - i) : i;
            logic [63:0] p = (w >> (k * pw)) & mask;
            exp_q.push_back(p);
            if (h) exp_q.push_back(p);
        end
    endfunction

    // One display cycle: present FIFO head, check outputs, then advance past the edge.
    task automatic cycle();
        f_empty = (fifo_q.size() == 0);
        f_data  = f_empty ? 64'd0 : fifo_q[0];
        #1;
        chk("line_end", {63'd0, lend_o}, {63'd0, lend_m[sel]});
        if (lend_o) lend_cnt++;
        if (req && !sync && vld_o) begin
            chk("exp_avail", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) chk("pixel", pix_o, exp_q.pop_front());
        end
        if (req && !sync && !vld_o) begin
            bubbles++;
            chk("uf_color", pix_o, 64'd0);
        end
        last_rd = rd_o;
        if (rd_o) begin
            pops++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        for (int d = 0; d < 2; d++) begin
            int   lp = d ? 8 : 640;
            logic r  = req && (int'(sel) == d);
            if (sync) begin
                lc_m[d] = 0; lend_m[d] = 1'b0;
            end else begin
                lend_m[d] = r && (lc_m[d] == lp - 1);
                if (r) lc_m[d] = (lc_m[d] == lp - 1) ? 0 : lc_m[d] + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_sync(input logic o, input logic h);
        sync = 1'b1; order = o; hdbl = h; req = 1'b0;
        cycle();
        sync = 1'b0; order = 1'b0; hdbl = 1'b0;
    endtask

    initial begin
        int n, reqn, per;
        vt[0] = '{1'b0, 1'b0, 1'b0, 2, 64'hBBBBAAAA, 64'hDDDDCCCC, 64'hAAAA, 2};
        vt[1] = '{1'b0, 1'b1, 1'b0, 2, 64'hBBBBAAAA, 64'hDDDDCCCC, 64'hBBBB, 2};
        vt[2] = '{1'b0, 1'b0, 1'b1, 2, 64'h22221111, 64'h44443333, 64'h1111, 2};
        vt[3] = '{1'b1, 1'b0, 1'b0, 2, 64'h0706050403020100, 64'h8F8E8D8C8B8A8988, 64'h00, 2};
        vt[4] = '{1'b1, 1'b1, 1'b0, 2, 64'h0706050403020100, 64'h8F8E8D8C8B8A8988, 64'h07, 2};
        vt[5] = '{1'b1, 1'b1, 1'b1, 1, 64'hF0E1D2C3B4A59687, 64'h0, 64'hF0, 1};
        lc_m = '{0, 0}; lend_m = '{1'b0, 1'b0};
        lend_cnt = 0; pops = 0; bubbles = 0; last_rd = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_valid", {63'd0, vld_o}, 64'd0);
        chk("rst_data", pix_o, 64'd0);
        chk("rst_rd_en", {63'd0, rd_o}, 64'd0);
        chk("rst_unf", {63'd0, unf_o}, 64'd0);
        chk("rst_lend", {63'd0, lend_o}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven streaming scenarios
        for (int v = 0; v < 6; v++) begin
            sel = vt[v].sel;
            do_sync(vt[v].ord, vt[v].hd);
            pops = 0; bubbles = 0;
            push_word(vt[v].w0, vt[v].sel, vt[v].ord, vt[v].hd);
            if (vt[v].nw > 1) push_word(vt[v].w1, vt[v].sel, vt[v].ord, vt[v].hd);
            cycle();
            per = (vt[v].sel ? 8 : 2) * (vt[v].hd ? 2 : 1);
            req = 1'b1; reqn = 0; n = 0;
            while (exp_q.size() != 0 && n < 64) begin
                reqn++;
                if (reqn == 1) chk("first_pix", pix_o, vt[v].first);
                cycle();
                if (last_rd) chk("pop_at_req", {32'd0, reqn % per}, 64'd0);
                n++;
            end
            req = 1'b0;
            chk("stream_done", {63'd0, n < 64}, 64'd1);
            chk("bubbles", bubbles, 64'd0);
            chk("pops", pops, vt[v].pops);
            cycle();
            chk("drained", {63'd0, vld_o}, 64'd0);
            chk("no_unf", {63'd0, unf_o}, 64'd0);
            exp_q.delete(); fifo_q.delete();
        end

        // Mid-word flush concurrent with a request
        sel = 1'b0;
        do_sync(1'b0, 1'b0);
        fifo_q.push_back(64'hBBBBAAAA);
        fifo_q.push_back(64'hDDDDCCCC);
        cycle();
        req = 1'b1; exp_q.push_back(64'hAAAA);
        cycle();
        sync = 1'b1;
        cycle();
        chk("sync_no_pop", {63'd0, last_rd}, 64'd0);
        sync = 1'b0; req = 1'b0;
        f_empty = (fifo_q.size() == 0); f_data = f_empty ? 64'd0 : fifo_q[0]; #1;
        chk("sync_valid", {63'd0, vld_o}, 64'd0);
        chk("sync_unf", {63'd0, unf_o}, 64'd0);
        cycle();
        chk("reload_pop", {63'd0, last_rd}, 64'd1);
        chk("reload_valid", {63'd0, vld_o}, 64'd1);
        chk("reload_pix", pix_o, 64'hCCCC);
        chk("sb_empty", exp_q.size(), 64'd0);
        do_sync(1'b0, 1'b0);
        fifo_q.delete();

        // Underflow on an empty FIFO, then line-end pulses over two lines
        lend_cnt = 0;
        req = 1'b1;
        chk("unf_before", {63'd0, unf_o}, 64'd0);
        cycle();
        chk("unf_set", {63'd0, unf_o}, 64'd1);
        for (int i = 1; i < 1280; i++) cycle();
        req = 1'b0;
        cycle(); cycle();
        chk("lend_pulses", lend_cnt, 64'd2);
        chk("unf_sticky", {63'd0, unf_o}, 64'd1);
        do_sync(1'b0, 1'b0);
        chk("unf_cleared", {63'd0, unf_o}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
